// File: rtl/cam_capture_pkg.sv
// Shared types and helpers for the parallel-camera capture packer.
package cam_capture_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_VS = 2'd1,
    ST_VS_ON   = 2'd2,
    ST_ACTIVE  = 2'd3
  } cap_state_e;

  // FIFO entry carries {sof, eol, packed word}
  function automatic int unsigned fifo_entry_width(input int unsigned dw, input int unsigned ppw);
    return dw * ppw + 2;
  endfunction

  function automatic logic vsync_active(input logic vs, input bit pol);
    return vs ^ ~pol;
  endfunction

  function automatic logic vsync_idle_level(input bit pol);
    return ~pol;
  endfunction

endpackage

// File: rtl/cam_capture_fifo.sv
// Synchronous first-word-fall-through FIFO; head entry is visible while valid is high.
module cam_capture_fifo #(
  parameter int unsigned WIDTH = 34,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             valid,
  output logic             full
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;
  logic             do_push;
  logic             do_pop;

  // a push into a full FIFO is accepted only when the head leaves in the same cycle
  assign do_pop  = pop & valid;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid   <= 1'b0;
      full    <= 1'b0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_d;
      valid   <= (count_d != '0);
      full    <= (count_d == CNT_W'(DEPTH));
    end
  end

endmodule

// File: rtl/cam_capture_packer.sv
// Camera capture: input registers, frame FSM, X/Y decimation, pixel packing and output FIFO.
module cam_capture_packer
  import cam_capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 8,
  parameter int unsigned PIXELS_PER_WORD = 4,
  parameter int unsigned FIFO_DEPTH      = 4,
  parameter int unsigned COL_BITS        = 10,
  parameter int unsigned ROW_BITS        = 9,
  parameter int unsigned VSYNC_POL       = 1
) (
  input  logic                                  clk,
  input  logic                                  resetn,
  input  logic                                  enable,
  input  logic [1:0]                            decim,
  input  logic [DATA_WIDTH-1:0]                 cam_dat,
  input  logic                                  cam_href,
  input  logic                                  cam_vsync,
  output logic [DATA_WIDTH*PIXELS_PER_WORD-1:0] out_data,
  output logic                                  out_sof,
  output logic                                  out_eol,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic                                  frame_done,
  output logic [ROW_BITS-1:0]                   line_count,
  output logic                                  overflow,
  input  logic                                  clear_ovf
);

  localparam int unsigned WORD_W  = DATA_WIDTH * PIXELS_PER_WORD;
  localparam int unsigned ENTRY_W = fifo_entry_width(DATA_WIDTH, PIXELS_PER_WORD);
  localparam int unsigned IDX_W   = (PIXELS_PER_WORD > 1) ? $clog2(PIXELS_PER_WORD) : 1;
  localparam bit          VS_POL  = 1'(VSYNC_POL);

  logic [DATA_WIDTH-1:0] reg_dat;
  logic                  reg_href;
  logic                  reg_vsync;
  logic                  vs_act;

  cap_state_e state_q;
  cap_state_e state_d;
  logic       frame_end_c;
  logic       enter_active_c;

  logic [COL_BITS-1:0] col_q;
  logic [ROW_BITS-1:0] row_q;
  logic [ROW_BITS-1:0] row_keep_q;
  logic [COL_BITS-1:0] col_mask;
  logic [ROW_BITS-1:0] row_mask;
  logic                line_px_c;
  logic                line_px_d;
  logic                line_end_c;
  logic                line_fall_c;
  logic                row_kept_c;
  logic                pix_keep_c;

  logic [WORD_W-1:0]   pack_q;
  logic [WORD_W-1:0]   word_c;
  logic [IDX_W-1:0]    idx_q;
  logic                sof_pend_q;
  logic                push_c;
  logic                pop_c;
  logic                drop_c;
  logic                fifo_full;
  logic [ENTRY_W-1:0]  push_entry;
  logic [ENTRY_W-1:0]  head_entry;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      reg_dat   <= '0;
      reg_href  <= 1'b0;
      reg_vsync <= vsync_idle_level(VS_POL);
    end else begin
      reg_dat   <= cam_dat;
      reg_href  <= cam_href;
      reg_vsync <= cam_vsync;
    end
  end

  assign vs_act = vsync_active(reg_vsync, VS_POL);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // enable is only looked at when leaving IDLE and at the end of a frame
  always_comb begin
    state_d        = state_q;
    frame_end_c    = 1'b0;
    enter_active_c = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_WAIT_VS;
      end
      ST_WAIT_VS: begin
        if (vs_act) state_d = ST_VS_ON;
      end
      ST_VS_ON: begin
        if (!vs_act) begin
          state_d        = ST_ACTIVE;
          enter_active_c = 1'b1;
        end
      end
      ST_ACTIVE: begin
        if (vs_act) begin
          frame_end_c = 1'b1;
          state_d     = enable ? ST_VS_ON : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign line_px_c   = (state_q == ST_ACTIVE) & ~vs_act & reg_href;
  // raw href going low tells us the registered pixel is the last of its line
  assign line_end_c  = line_px_c & ~cam_href;
  assign line_fall_c = line_px_d & ~line_px_c;
  assign col_mask    = ~({COL_BITS{1'b1}} << decim);
  assign row_mask    = ~({ROW_BITS{1'b1}} << decim);
  assign row_kept_c  = ((row_q & row_mask) == '0);
  assign pix_keep_c  = line_px_c & ((col_q & col_mask) == '0) & row_kept_c;

  always_comb begin
    word_c = pack_q;
    if (pix_keep_c) begin
      word_c[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH] = reg_dat;
    end
  end

  assign push_c = (pix_keep_c & (idx_q == IDX_W'(PIXELS_PER_WORD - 1)))
                | (line_end_c & (pix_keep_c | (idx_q != '0)));
  assign push_entry = {sof_pend_q, line_end_c, word_c};
  assign pop_c      = out_valid & out_ready;
  assign drop_c     = push_c & fifo_full & ~pop_c;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_q      <= '0;
      row_q      <= '0;
      row_keep_q <= '0;
      line_px_d  <= 1'b0;
    end else begin
      line_px_d <= line_px_c;
      if (enter_active_c) begin
        col_q      <= '0;
        row_q      <= '0;
        row_keep_q <= '0;
      end else begin
        if (line_px_c) begin
          if (col_q != {COL_BITS{1'b1}}) col_q <= col_q + 1'b1;
        end else if (line_fall_c) begin
          col_q <= '0;
        end
        if (line_fall_c) begin
          if (row_q != {ROW_BITS{1'b1}}) row_q <= row_q + 1'b1;
          if (row_kept_c && row_keep_q != {ROW_BITS{1'b1}}) row_keep_q <= row_keep_q + 1'b1;
        end
      end
    end
  end

  // slot buffer is zeroed after every push so flushed partial words carry zero padding
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pack_q     <= '0;
      idx_q      <= '0;
      sof_pend_q <= 1'b0;
    end else if (enter_active_c) begin
      pack_q     <= '0;
      idx_q      <= '0;
      sof_pend_q <= 1'b1;
    end else if (push_c) begin
      pack_q     <= '0;
      idx_q      <= '0;
      sof_pend_q <= 1'b0;
    end else if (pix_keep_c) begin
      pack_q <= word_c;
      idx_q  <= idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      frame_done <= 1'b0;
      line_count <= '0;
      overflow   <= 1'b0;
    end else begin
      frame_done <= frame_end_c;
      if (frame_end_c) line_count <= row_keep_q;
      if (drop_c) begin
        overflow <= 1'b1;
      end else if (clear_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  cam_capture_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push_c),
    .wdata  (push_entry),
    .pop    (pop_c),
    .rdata  (head_entry),
    .valid  (out_valid),
    .full   (fifo_full)
  );

  assign out_data = head_entry[WORD_W-1:0];
  assign out_eol  = head_entry[WORD_W];
  assign out_sof  = head_entry[WORD_W+1];

endmodule

// File: tb/tb_cam_capture_packer.sv
// Self-checking bench for cam_capture_packer: frame table plus overflow, enable and reset sequences.
module tb_cam_capture_packer;

  localparam int PPW = 4;

  logic        clk;
  logic        resetn;
  logic        enable;
  logic [1:0]  decim;
  logic [7:0]  cam_dat;
  logic        cam_href;
  logic        cam_vsync;
  logic [31:0] out_data;
  logic        out_sof;
  logic        out_eol;
  logic        out_valid;
  logic        out_ready;
  logic        frame_done;
  logic [8:0]  line_count;
  logic        overflow;
  logic        clear_ovf;

  cam_capture_packer #(
    .DATA_WIDTH      (8),
    .PIXELS_PER_WORD (PPW),
    .FIFO_DEPTH      (4),
    .COL_BITS        (10),
    .ROW_BITS        (9),
    .VSYNC_POL       (1)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .enable     (enable),
    .decim      (decim),
    .cam_dat    (cam_dat),
    .cam_href   (cam_href),
    .cam_vsync  (cam_vsync),
    .out_data   (out_data),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .frame_done (frame_done),
    .line_count (line_count),
    .overflow   (overflow),
    .clear_ovf  (clear_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int npix;
    int nlines;
    int dec;
    int base;
    int exp_words;
    int exp_lc;
  } frame_vec_t;

  typedef struct packed {
    logic        sof;
    logic        eol;
    logic [31:0] data;
  } word_t;

  frame_vec_t vecs[5];
  word_t      exp_q[$];
  word_t      got_log[$];
  int         checks;
  int         errors;
  int         nwords;
  int         ndone;
  logic [8:0] last_lc;
  bit         model_sof;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // output monitor: sampled on the falling edge, compares each accepted word with the scoreboard
  always @(negedge clk) begin
    word_t got;
    word_t e;
    if (resetn) begin
      if (frame_done) begin
        ndone++;
        last_lc = line_count;
      end
      if (out_valid && out_ready) begin
        got = {out_sof, out_eol, out_data};
        got_log.push_back(got);
        nwords++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: unexpected word %h, scoreboard empty", got);
        end else begin
          e = exp_q.pop_front();
          check("word", 64'(got), 64'(e));
        end
      end
    end
  end

  task automatic vsync_pulse();
    tick();
    cam_vsync = 1'b1;
    repeat (3) tick();
    cam_vsync = 1'b0;
    model_sof = 1'b1;
    repeat (3) tick();
  endtask

  // drives one line and, if expect_out, queues the words a correct packer would produce
  task automatic drive_line(input int npix, input int row, input int dec, inout int val, input bit expect_out);
    logic [31:0] w;
    int slot;
    int m;
    m = (1 << dec) - 1;
    w = '0;
    slot = 0;
    for (int i = 0; i < npix; i++) begin
      tick();
      cam_href = 1'b1;
      cam_dat  = 8'(val);
      val++;
      if (expect_out && ((i & m) == 0) && ((row & m) == 0)) begin
        w[slot*8 +: 8] = cam_dat;
        slot++;
        if (slot == PPW) begin
          exp_q.push_back({model_sof, (i == npix - 1), w});
          model_sof = 1'b0;
          w = '0;
          slot = 0;
        end
      end
    end
    tick();
    cam_href = 1'b0;
    cam_dat  = '0;
    if (expect_out && slot != 0) begin
      exp_q.push_back({model_sof, 1'b1, w});
      model_sof = 1'b0;
    end
    repeat (4) tick();
  endtask

  task automatic run_frame(input int v);
    int w0;
    int d0;
    int val;
    w0  = nwords;
    d0  = ndone;
    val = vecs[v].base;
    for (int r = 0; r < vecs[v].nlines; r++) begin
      drive_line(vecs[v].npix, r, vecs[v].dec, val, 1'b1);
    end
    vsync_pulse();
    repeat (6) tick();
    check($sformatf("frame%0d words", v), 64'(nwords - w0), 64'(vecs[v].exp_words));
    check($sformatf("frame%0d done", v), 64'(ndone - d0), 64'd1);
    check($sformatf("frame%0d line_count", v), 64'(last_lc), 64'(vecs[v].exp_lc));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int w0;
    int d0;
    int val;
    word_t tmp;

    vecs[0] = '{npix: 8,  nlines: 2, dec: 0, base: 'h01, exp_words: 4, exp_lc: 2};
    vecs[1] = '{npix: 6,  nlines: 1, dec: 0, base: 'h01, exp_words: 2, exp_lc: 1};
    vecs[2] = '{npix: 8,  nlines: 4, dec: 1, base: 'h00, exp_words: 2, exp_lc: 2};
    vecs[3] = '{npix: 5,  nlines: 3, dec: 2, base: 'h40, exp_words: 1, exp_lc: 1};
    vecs[4] = '{npix: 12, nlines: 2, dec: 0, base: 'h80, exp_words: 6, exp_lc: 2};

    checks = 0; errors = 0; nwords = 0; ndone = 0; last_lc = '0; model_sof = 1'b0;
    resetn = 1'b0; enable = 1'b0; decim = '0; cam_dat = '0; cam_href = 1'b0;
    cam_vsync = 1'b0; out_ready = 1'b1; clear_ovf = 1'b0;

    #3;
    check("reset out_valid",  64'(out_valid),  64'd0);
    check("reset out_data",   64'(out_data),   64'd0);
    check("reset out_sof",    64'(out_sof),    64'd0);
    check("reset out_eol",    64'(out_eol),    64'd0);
    check("reset frame_done", 64'(frame_done), 64'd0);
    check("reset line_count", 64'(line_count), 64'd0);
    check("reset overflow",   64'(overflow),   64'd0);

    repeat (2) tick();
    resetn = 1'b1;
    enable = 1'b1;
    repeat (2) tick();
    vsync_pulse();

    for (int v = 0; v < 5; v++) begin
      decim = 2'(vecs[v].dec);
      run_frame(v);
    end

    check("f0 word0", 64'(got_log[0]), 64'({1'b1, 1'b0, 32'h04030201}));
    check("f0 word1", 64'(got_log[1]), 64'({1'b0, 1'b1, 32'h08070605}));
    check("f0 word3", 64'(got_log[3]), 64'({1'b0, 1'b1, 32'h10 << 24 | 32'h000F0E0D}));
    check("f1 word0", 64'(got_log[4]), 64'({1'b1, 1'b0, 32'h04030201}));
    check("f1 partial", 64'(got_log[5]), 64'({1'b0, 1'b1, 32'h00000605}));
    check("f2 row0 data", 64'(got_log[6].data), 64'h06040200);
    check("f2 row0 sof", 64'(got_log[6].sof), 64'd1);
    check("f2 row2 data", 64'(got_log[7].data), 64'h16141210);

    // overflow: consumer stalled while a 6-word line arrives into a 4-deep FIFO
    decim = 2'd0;
    out_ready = 1'b0;
    w0 = nwords;
    val = 'hA0;
    drive_line(24, 0, 0, val, 1'b1);
    repeat (2) tick();
    check("ovf out_valid held", 64'(out_valid), 64'd1);
    check("ovf sticky set", 64'(overflow), 64'd1);
    check("ovf head data", 64'(out_data), 64'hA3A2A1A0);
    check("ovf head sof", 64'(out_sof), 64'd1);
    check("ovf queued model", 64'(exp_q.size()), 64'd6);
    tmp = exp_q.pop_back();
    tmp = exp_q.pop_back();
    out_ready = 1'b1;
    repeat (8) tick();
    check("ovf retained words", 64'(nwords - w0), 64'd4);
    check("ovf still set", 64'(overflow), 64'd1);
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    tick();
    check("ovf cleared", 64'(overflow), 64'd0);
    d0 = ndone;
    vsync_pulse();
    repeat (4) tick();
    check("ovf frame done", 64'(ndone - d0), 64'd1);
    check("ovf line_count", 64'(last_lc), 64'd1);

    // enable dropped mid-frame: frame completes, following frame ignored
    w0 = nwords;
    d0 = ndone;
    val = 'h01;
    drive_line(8, 0, 0, val, 1'b1);
    enable = 1'b0;
    drive_line(8, 1, 0, val, 1'b1);
    vsync_pulse();
    repeat (4) tick();
    check("en frame done", 64'(ndone - d0), 64'd1);
    check("en line_count", 64'(last_lc), 64'd2);
    check("en words", 64'(nwords - w0), 64'd4);
    w0 = nwords;
    d0 = ndone;
    drive_line(8, 0, 0, val, 1'b0);
    vsync_pulse();
    repeat (4) tick();
    check("idle no done", 64'(ndone - d0), 64'd0);
    check("idle no words", 64'(nwords - w0), 64'd0);
    check("idle out_valid", 64'(out_valid), 64'd0);
    enable = 1'b1;
    repeat (2) tick();
    vsync_pulse();

    // reset mid-line with words still queued
    out_ready = 1'b0;
    val = 'h20;
    drive_line(8, 0, 0, val, 1'b1);
    check("pre-reset out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      cam_href = 1'b1;
      cam_dat  = 8'(val);
      val++;
    end
    #2;
    resetn = 1'b0;
    #1;
    check("mid reset out_valid",  64'(out_valid),  64'd0);
    check("mid reset out_data",   64'(out_data),   64'd0);
    check("mid reset out_sof",    64'(out_sof),    64'd0);
    check("mid reset out_eol",    64'(out_eol),    64'd0);
    check("mid reset line_count", 64'(line_count), 64'd0);
    check("mid reset frame_done", 64'(frame_done), 64'd0);
    exp_q.delete();
    tick();
    tick();
    resetn = 1'b1;
    out_ready = 1'b1;
    w0 = nwords;
    for (int i = 0; i < 5; i++) begin
      tick();
      cam_href = 1'b1;
      cam_dat  = 8'(val);
      val++;
    end
    tick();
    cam_href = 1'b0;
    cam_dat  = '0;
    repeat (6) tick();
    check("post reset partial line ignored", 64'(nwords - w0), 64'd0);
    vsync_pulse();
    w0 = nwords;
    d0 = ndone;
    val = 'h55;
    drive_line(4, 0, 0, val, 1'b1);
    vsync_pulse();
    repeat (4) tick();
    check("post reset words", 64'(nwords - w0), 64'd1);
    check("post reset done", 64'(ndone - d0), 64'd1);
    check("post reset line_count", 64'(last_lc), 64'd1);
    check("post reset word", 64'(got_log[got_log.size()-1]), 64'({1'b1, 1'b1, 32'h58575655}));

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
